// File: rtl/tage_upd_if.sv
// Resolved-branch record channel from the branch resolution unit to the TAGE update engine.
// Latency: none, plain wires.
// Backpressure: upd_ready from the slave qualifies upd_valid; a record transfers when both are high.
interface tage_upd_if #(
  parameter int NT    = 4,
  parameter int IDX_W = 8,
  parameter int TAG_W = 8,
  parameter int CTR_W = 3,
  parameter int U_W   = 2
);
  logic                  upd_valid;
  logic                  upd_ready;
  logic                  upd_taken;
  logic                  upd_pred;
  logic                  upd_alt;
  logic [2:0]            upd_prov;
  logic [IDX_W-1:0]      upd_base_idx;
  logic [1:0]            upd_base_ctr;
  logic [NT*IDX_W-1:0]   upd_idx;
  logic [NT*TAG_W-1:0]   upd_tag;
  logic [CTR_W-1:0]      upd_ctr;
  logic [NT*U_W-1:0]     upd_u;

  modport master (
    output upd_valid, upd_taken, upd_pred, upd_alt, upd_prov, upd_base_idx,
           upd_base_ctr, upd_idx, upd_tag, upd_ctr, upd_u,
    input  upd_ready
  );

  modport slave (
    input  upd_valid, upd_taken, upd_pred, upd_alt, upd_prov, upd_base_idx,
           upd_base_ctr, upd_idx, upd_tag, upd_ctr, upd_u,
    output upd_ready
  );
endinterface

// File: rtl/tage_update_ctrl.sv
// TAGE training engine: provider ctr/useful update, mispredict allocation, periodic useful sweep.
// Latency: accept->IDLE 2 cycles, 3 with allocation, plus 2^IDX_W cycles when a sweep runs.
// Backpressure: upd_ready only in IDLE; define TAGE_ALLOC_RAND_EN for LFSR-randomised allocation.
module tage_update_ctrl #(
  parameter int NT      = 4,
  parameter int IDX_W   = 8,
  parameter int TAG_W   = 8,
  parameter int CTR_W   = 3,
  parameter int U_W     = 2,
  parameter int RST_LOG = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  tage_upd_if.slave           upd,
  output logic                base_we,
  output logic [IDX_W-1:0]    base_widx,
  output logic [1:0]          base_wctr,
  output logic [NT-1:0]       tbl_we,
  output logic [NT-1:0]       tbl_uwe,
  output logic [NT*IDX_W-1:0] tbl_widx,
  output logic [TAG_W-1:0]    tbl_wtag,
  output logic [CTR_W-1:0]    tbl_wctr,
  output logic [NT*U_W-1:0]   tbl_wu,
  output logic                busy
);

  typedef enum logic [1:0] {S_IDLE, S_UPD, S_ALLOC, S_SWEEP} state_e;

  localparam logic [CTR_W-1:0]   CTR_MAX     = '1;
  localparam logic [CTR_W-1:0]   CTR_ONE     = CTR_W'(1);
  localparam logic [CTR_W-1:0]   CTR_WEAK_T  = {1'b1, {(CTR_W-1){1'b0}}};
  localparam logic [CTR_W-1:0]   CTR_WEAK_NT = {1'b0, {(CTR_W-1){1'b1}}};
  localparam logic [U_W-1:0]     U_MAX       = '1;
  localparam logic [U_W-1:0]     U_ONE       = U_W'(1);
  localparam logic [2:0]         PROV_NT     = 3'(NT);
  localparam logic [RST_LOG-1:0] CNT_ONE     = RST_LOG'(1);
  localparam logic [IDX_W-1:0]   SIDX_ONE    = IDX_W'(1);
  localparam logic [IDX_W-1:0]   SIDX_LAST   = '1;

  state_e               state_q, state_d;
  logic                 taken_q, taken_d;
  logic                 pred_q, pred_d;
  logic                 alt_q, alt_d;
  logic [2:0]           prov_q, prov_d;
  logic [IDX_W-1:0]     bidx_q, bidx_d;
  logic [1:0]           bctr_q, bctr_d;
  logic [NT*IDX_W-1:0]  idx_q, idx_d;
  logic [NT*TAG_W-1:0]  tag_q, tag_d;
  logic [CTR_W-1:0]     ctr_q, ctr_d;
  logic [NT*U_W-1:0]    u_q, u_d;
  logic [RST_LOG-1:0]   cnt_q, cnt_d;
  logic                 wrap_q, wrap_d;
  logic [IDX_W-1:0]     sidx_q, sidx_d;

  logic                 accept;
  logic [NT-1:0]        prov_sel;
  logic [U_W-1:0]       prov_u_old;
  logic [U_W-1:0]       prov_u_new;
  logic [CTR_W-1:0]     prov_ctr_new;
  logic [1:0]           base_ctr_new;
  logic [NT-1:0]        cand_first;
  logic                 cand_any;
  logic [NT-1:0]        alloc_oh;

`ifdef TAGE_ALLOC_RAND_EN
  logic [3:0]           lfsr_q, lfsr_d;
  logic [NT-1:0]        cand_second;
  logic                 cand_two;
`endif

  assign accept = (state_q == S_IDLE) && upd.upd_valid;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Latched record, update counter and sweep index
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      taken_q <= 1'b0;
      pred_q  <= 1'b0;
      alt_q   <= 1'b0;
      prov_q  <= '0;
      bidx_q  <= '0;
      bctr_q  <= '0;
      idx_q   <= '0;
      tag_q   <= '0;
      ctr_q   <= '0;
      u_q     <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      sidx_q  <= '0;
    end else begin
      taken_q <= taken_d;
      pred_q  <= pred_d;
      alt_q   <= alt_d;
      prov_q  <= prov_d;
      bidx_q  <= bidx_d;
      bctr_q  <= bctr_d;
      idx_q   <= idx_d;
      tag_q   <= tag_d;
      ctr_q   <= ctr_d;
      u_q     <= u_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      sidx_q  <= sidx_d;
    end
  end

  // Capture the record on accept, count updates, step the sweep index
  always_comb begin
    taken_d = taken_q;
    pred_d  = pred_q;
    alt_d   = alt_q;
    prov_d  = prov_q;
    bidx_d  = bidx_q;
    bctr_d  = bctr_q;
    idx_d   = idx_q;
    tag_d   = tag_q;
    ctr_d   = ctr_q;
    u_d     = u_q;
    cnt_d   = cnt_q;
    wrap_d  = wrap_q;
    sidx_d  = sidx_q;
    if (accept) begin
      taken_d = upd.upd_taken;
      pred_d  = upd.upd_pred;
      alt_d   = upd.upd_alt;
      prov_d  = upd.upd_prov;
      bidx_d  = upd.upd_base_idx;
      bctr_d  = upd.upd_base_ctr;
      idx_d   = upd.upd_idx;
      tag_d   = upd.upd_tag;
      ctr_d   = upd.upd_ctr;
      u_d     = upd.upd_u;
      cnt_d   = cnt_q + CNT_ONE;
      // This accept wraps the counter to zero: a sweep follows the update
      wrap_d  = (cnt_q == '1);
    end
    if (state_q == S_SWEEP) sidx_d = sidx_q + SIDX_ONE;
  end

`ifdef TAGE_ALLOC_RAND_EN
  // Allocation LFSR, x^4+x^3+1, steps once per accepted update
  always_ff @(posedge clk) begin
    if (!rst_n) lfsr_q <= 4'b0001;
    else        lfsr_q <= lfsr_d;
  end

  // LFSR next value
  always_comb begin
    lfsr_d = lfsr_q;
    if (accept) lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
  end
`endif

  // Provider-side saturating counter and useful-bit arithmetic
  always_comb begin
    prov_sel   = '0;
    prov_u_old = '0;
    for (int k = 0; k < NT; k++) begin
      if (prov_q == 3'(k + 1)) begin
        prov_sel[k] = 1'b1;
        prov_u_old  = u_q[k*U_W +: U_W];
      end
    end
    if (taken_q) prov_ctr_new = (ctr_q == CTR_MAX) ? CTR_MAX : ctr_q + CTR_ONE;
    else         prov_ctr_new = (ctr_q == '0) ? '0 : ctr_q - CTR_ONE;
    if (taken_q) base_ctr_new = (bctr_q == 2'd3) ? 2'd3 : bctr_q + 2'd1;
    else         base_ctr_new = (bctr_q == 2'd0) ? 2'd0 : bctr_q - 2'd1;
    // Usefulness only moves when the provider disagreed with the alternate
    prov_u_new = prov_u_old;
    if (pred_q != alt_q) begin
      if (pred_q == taken_q) prov_u_new = (prov_u_old == U_MAX) ? U_MAX : prov_u_old + U_ONE;
      else                   prov_u_new = (prov_u_old == '0) ? '0 : prov_u_old - U_ONE;
    end
  end

  // Allocation candidates: longer-history tables than the provider with u==0
  always_comb begin
    cand_first = '0;
    cand_any   = 1'b0;
`ifdef TAGE_ALLOC_RAND_EN
    cand_second = '0;
    cand_two    = 1'b0;
`endif
    for (int k = 0; k < NT; k++) begin
      if ((k >= int'(prov_q)) && (u_q[k*U_W +: U_W] == '0)) begin
        if (!cand_any) begin
          cand_first[k] = 1'b1;
          cand_any      = 1'b1;
        end
`ifdef TAGE_ALLOC_RAND_EN
        else if (!cand_two) begin
          cand_second[k] = 1'b1;
          cand_two       = 1'b1;
        end
`endif
      end
    end
`ifdef TAGE_ALLOC_RAND_EN
    alloc_oh = (cand_two && lfsr_q[0]) ? cand_second : cand_first;
`else
    alloc_oh = cand_first;
`endif
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (upd.upd_valid) state_d = S_UPD;
      S_UPD: begin
        if ((pred_q != taken_q) && (prov_q < PROV_NT)) state_d = S_ALLOC;
        else if (wrap_q)                               state_d = S_SWEEP;
        else                                           state_d = S_IDLE;
      end
      S_ALLOC: state_d = wrap_q ? S_SWEEP : S_IDLE;
      S_SWEEP: if (sidx_q == SIDX_LAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Write-port outputs; everything is zero outside the cycle that writes it
  always_comb begin
    upd.upd_ready = (state_q == S_IDLE);
    busy          = (state_q != S_IDLE);
    base_we       = 1'b0;
    base_widx     = '0;
    base_wctr     = '0;
    tbl_we        = '0;
    tbl_uwe       = '0;
    tbl_widx      = '0;
    tbl_wtag      = '0;
    tbl_wctr      = '0;
    tbl_wu        = '0;
    case (state_q)
      S_UPD: begin
        if (prov_q == '0) begin
          base_we   = 1'b1;
          base_widx = bidx_q;
          base_wctr = base_ctr_new;
        end else begin
          for (int k = 0; k < NT; k++) begin
            if (prov_sel[k]) begin
              tbl_we[k]                  = 1'b1;
              tbl_widx[k*IDX_W +: IDX_W] = idx_q[k*IDX_W +: IDX_W];
              tbl_wtag                   = tag_q[k*TAG_W +: TAG_W];
              tbl_wctr                   = prov_ctr_new;
              tbl_wu[k*U_W +: U_W]       = prov_u_new;
            end
          end
        end
      end
      S_ALLOC: begin
        if (cand_any) begin
          for (int k = 0; k < NT; k++) begin
            if (alloc_oh[k]) begin
              tbl_we[k]                  = 1'b1;
              tbl_widx[k*IDX_W +: IDX_W] = idx_q[k*IDX_W +: IDX_W];
              tbl_wtag                   = tag_q[k*TAG_W +: TAG_W];
              tbl_wctr                   = taken_q ? CTR_WEAK_T : CTR_WEAK_NT;
            end
          end
        end else begin
          // No free entry: age every longer-history entry so one frees up later
          for (int k = 0; k < NT; k++) begin
            if (k >= int'(prov_q)) begin
              tbl_uwe[k]                 = 1'b1;
              tbl_widx[k*IDX_W +: IDX_W] = idx_q[k*IDX_W +: IDX_W];
              tbl_wu[k*U_W +: U_W]       = (u_q[k*U_W +: U_W] == '0) ? '0
                                         : u_q[k*U_W +: U_W] - U_ONE;
            end
          end
        end
      end
      S_SWEEP: begin
        tbl_uwe = '1;
        for (int k = 0; k < NT; k++) tbl_widx[k*IDX_W +: IDX_W] = sidx_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/tage_update_ctrl.md
Name: tage_update_ctrl

Overview:
- Training/write-back engine for the dtage predictor. The predictor reads its tables and produces `prediction`; this block writes them back.
- Accepts one resolved-branch record per transaction. Each record carries the outcome plus the snapshot the predictor used.
- Performs provider counter/useful updates, mispredict allocation, and periodic useful-bit sweeps through the table write ports.

Parameters:
- NT, 4, number of tagged tables (table 1 = shortest history, NT = longest).
- IDX_W, 8, index width per table (base and tagged).
- TAG_W, 8, tag width.
- CTR_W, 3, tagged prediction counter width (signed-style, MSB = taken).
- U_W, 2, useful counter width.
- RST_LOG, 8, useful sweep period = 2^RST_LOG accepted updates.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  reset, synchronous, active-low.
- upd_valid  in  1  resolved-branch record valid.
- upd_ready  out  1  block can accept a record.
- upd_taken  in  1  actual outcome.
- upd_pred  in  1  final prediction issued.
- upd_alt  in  1  alternate prediction.
- upd_prov  in  3  provider table: 0 = base, 1..NT = tagged.
- upd_base_idx  in  IDX_W  base table index.
- upd_base_ctr  in  2  base counter read value.
- upd_idx  in  NT*IDX_W  per-table index, table k at slice k-1.
- upd_tag  in  NT*TAG_W  per-table computed tag.
- upd_ctr  in  CTR_W  provider counter read value.
- upd_u  in  NT*U_W  per-table useful read values.
- base_we  out  1  base write enable.
- base_widx  out  IDX_W  base write index.
- base_wctr  out  2  base write data.
- tbl_we  out  NT  full-entry write {tag,ctr,u} per table.
- tbl_uwe  out  NT  useful-only write per table.
- tbl_widx  out  NT*IDX_W  write index per table.
- tbl_wtag  out  TAG_W  tag data (shared).
- tbl_wctr  out  CTR_W  ctr data (shared).
- tbl_wu  out  NT*U_W  useful data per table.
- busy  out  1  high in any state but IDLE.

Behaviour:
- States: IDLE, UPD, ALLOC, SWEEP.
- Reset: state=IDLE, upd_ready=1, busy=0, all write enables 0, all data outputs 0, update counter 0, sweep index 0. Reset in any state (including mid-SWEEP) aborts immediately with no further writes.
- Write enables are single-cycle pulses.
- IDLE:
  - upd_ready=1.
  - On upd_valid: latch all upd_* fields, increment update counter (mod 2^RST_LOG), go to UPD.
  - upd_ready is 0 in all other states; upd_valid is ignored there.
- UPD (cycle after accept):
  - If prov=0: base_we=1, base_widx=latched idx. base_wctr = upd_base_ctr saturating +1 if taken, −1 if not taken (range 0..3).
  - If prov=k>0: tbl_we[k-1]=1. tag = latched tag k; ctr = upd_ctr saturating toward outcome (range 0..2^CTR_W−1). u = upd_u[k] +1 (sat at 2^U_W−1) if upd_pred!=upd_alt and upd_pred==taken; −1 (sat at 0) if upd_pred!=upd_alt and upd_pred!=taken; otherwise unchanged.
  - Next state: ALLOC if upd_pred!=upd_taken and prov<NT. Else SWEEP if counter wrapped to 0 on this accept. Else IDLE.
- ALLOC (one cycle):
  - Candidates: tables j in prov+1..NT with u[j]==0. Choose the lowest j.
  - If a candidate exists: tbl_we[j-1]=1, tag = tag j, ctr = taken ? 2^(CTR_W−1) : 2^(CTR_W−1)−1 (4/3 for CTR_W=3), u=0.
  - If no candidate: tbl_uwe pulses for all j>prov, wu = u[j]−1 (u[j]>0 guaranteed).
  - Then go to SWEEP if wrapped, else IDLE.
- SWEEP:
  - Each cycle: tbl_uwe=all ones, every tbl_widx slice = sweep index, tbl_wu=0; sweep index increments.
  - Lasts exactly 2^IDX_W cycles, after which the sweep index is 0 again and the block returns to IDLE.
- Transaction latency, accept to IDLE: 2 cycles (no alloc), 3 cycles (alloc), +2^IDX_W cycles when a sweep runs.

Optional Feature:
- Macro: TAGE_ALLOC_RAND_EN.
- When defined: a 4-bit LFSR (x^4+x^3+1, reset value 4'b0001) advances every accepted update. If ≥2 candidates exist and LFSR[0]=1, the second-lowest candidate is chosen instead of the lowest.
- When undefined: no LFSR logic; the lowest candidate is always chosen.

Test Plan:
- Reset: after rst_n=0 for 1 cycle, upd_ready=1, busy=0, all we=0; then hold upd_valid=1 with prov=0, base_ctr=3, taken=1 → one UPD cycle: base_we=1, base_wctr=3 (saturated), idle next cycle.
- Tagged update: prov=2, upd_ctr=6, taken=1, pred=1, alt=0, u2=1 → tbl_we=4'b0010, wctr=7, wu slice1=2, no ALLOC.
- Alloc: prov=1, pred=1, taken=0, u={t2=1,t3=0,t4=0} → ALLOC cycle: tbl_we=4'b0100, wctr=3, wu=0, wtag=tag3.
- No free slot: prov=2, mispredict, u3=2, u4=1 → ALLOC: tbl_uwe=4'b1100, wu3=1, wu4=0.
- Sweep: 256th accepted update → after its last write, busy stays high for 256 cycles, tbl_uwe=4'hF, widx 0..255; then upd_ready=1.
- Reset mid-SWEEP at index 17 → next cycle IDLE, no uwe pulses; a subsequent sweep starts at index 0.
